if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage for the RV32I core.
- Owns the PC register and drives a single-outstanding request/ack instruction-memory port.
- Produces the IF/ID pipeline register.
- Consumes the EX-stage branch decision (taken flag from branch_cond, qualified by EX as a valid branch) and target. A taken branch redirects the PC and flushes the wrong-path fetch.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- XLEN, 32, PC and instruction width.

Ports:
- i_clk  in  1  core clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_stall  in  1  hazard unit holds IF/ID.
- i_branch_taken  in  1  EX redirect request, single-cycle pulse.
- i_branch_target  in  XLEN  redirect address.
- o_imem_req  out  1  fetch request.
- o_imem_addr  out  XLEN  fetch address.
- i_imem_ack  in  1  response valid; may arrive combinationally in the same cycle as o_imem_req.
- i_imem_rdata  in  XLEN  instruction word, valid with ack.
- o_if_valid  out  1  IF/ID holds a real instruction.
- o_if_pc  out  XLEN  PC of the IF/ID instruction.
- o_if_pc_plus4  out  XLEN  o_if_pc + 4.
- o_if_instr  out  XLEN  instruction word; INSTR_NOP when invalid.

Behaviour:
- Reset (asynchronous, i_rst=1):
  - pc=RESET_PC, state=BOOT, o_imem_req=0, o_if_valid=0.
  - o_if_pc=0, o_if_pc_plus4=0, o_if_instr=INSTR_NOP.
  - Pending redirect and skid buffer cleared.
- Reset mid-operation abandons any outstanding request; memory must tolerate a dropped request.
- BOOT: one idle cycle after reset release, then FETCH.
- FETCH:
  - o_imem_req=1, o_imem_addr=pc.
  - req/addr stay stable until ack.
  - At most one request outstanding.
- Ack in FETCH, no redirect active/pending, and (!i_stall or !o_if_valid):
  - IF/ID <= {valid=1, pc, pc+4, rdata}.
  - pc <= pc+4.
  - Stay in FETCH.
- Ack in FETCH while i_stall and o_if_valid:
  - Store {pc, rdata} in the skid buffer; pc <= pc+4.
  - Go to HOLD with req=0.
- HOLD: when !i_stall, skid contents move to IF/ID, then return to FETCH.
- Stall with IF/ID valid: all o_if_* hold.
- No ack and !i_stall: o_if_valid <= 0, i.e. the consumed entry drains.
- Redirect (i_branch_taken=1) in any state except BOOT:
  - The IF/ID flush has priority over stall: o_if_valid <= 0 next cycle and o_if_instr <= INSTR_NOP.
  - The skid buffer is discarded.
  - If no request is outstanding, or ack arrives in the same cycle: pc <= {target[31:2],2'b00}; the ack data is discarded; state FETCH.
  - If a request is outstanding without ack: latch pend_valid/pend_target and keep req/addr stable.
  - On the later ack: discard the data, pc <= pend_target, clear pend_valid.
- A second redirect while one is pending overwrites pend_target (youngest wins).
- Arithmetic:
  - pc+4 wraps modulo 2^32; 32'hFFFF_FFFC is followed by 32'h0000_0000.
  - target bits [1:0] are forced to 0.
- Latency:
  - Zero-wait memory: first o_if_valid=1 in the 2nd cycle after reset release.
  - Taken-branch penalty is 2 cycles (target instruction valid 2 cycles after the redirect pulse).
  - Sustained throughput is 1 instr/cycle.

Decomposition:
- rv_pkg gains:
  - fetch_state_e {FETCH_BOOT, FETCH_REQ, FETCH_HOLD}.
  - INSTR_NOP = 32'h0000_0013.
  - DEFAULT_RESET_PC.
- Sub-module fetch_skid: one-entry {pc, instr} buffer with load/clear/valid, instantiated once.
- PC-next mux stays inline.

Test Plan:
- Reset release, ack tied 1, no stall → o_imem_addr 0, 4, 8, … each cycle; o_if_valid rises in the 2nd cycle with o_if_pc=0, then o_if_pc=4, 8.
- Branch pulse, target 0x100, zero-wait memory → next o_if_valid=0; o_imem_addr=0x100 the following cycle; o_if_pc=0x100 valid 2 cycles after the pulse; no 0x0C instruction is delivered.
- Ack delayed 3 cycles and a branch to 0x200 in the first wait cycle → addr held stable until ack; that response is discarded; next request is at 0x200.
- i_stall held 4 cycles with IF/ID valid → o_if_* frozen; one response captured in skid; no request issued during HOLD; on release, skid instruction appears, then fetch resumes at +4 with no loss or duplicate.
- pc=0xFFFF_FFFC, ack=1 → next address 0x0000_0000; branch target 0x0000_0103 → fetch at 0x0000_0100.
- i_rst asserted mid-wait with stall active → outputs reset immediately (asynchronous); after release, fetch restarts at RESET_PC; old ack ignored.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: fetch FSM states and architectural constants.
package rv_pkg;

    localparam int unsigned RV_XLEN = 32;

    // addi x0, x0, 0
    localparam logic [RV_XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [RV_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry {pc, instr} buffer that catches a fetch response arriving while IF/ID is stalled.
module fetch_skid
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_instr,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instr
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;

    // Clear wins over load so a redirect always empties the buffer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= XLEN'(INSTR_NOP);
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: PC register, single-outstanding imem port, IF/ID register.
module if_fetch_stage
    import rv_pkg::*;
#(
    parameter int unsigned     XLEN     = RV_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_branch_target,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_if_valid,
    output logic [XLEN-1:0] o_if_pc,
    output logic [XLEN-1:0] o_if_pc_plus4,
    output logic [XLEN-1:0] o_if_instr
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_imem_req;
    logic            r_pend_valid;
    logic [XLEN-1:0] r_pend_target;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_pc_plus4;
    logic [XLEN-1:0] r_if_instr;

    logic            w_redirect;
    logic            w_ack;
    logic            w_deliver;
    logic            w_skid_pop;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_next;
    logic            w_skid_load;
    logic            w_skid_clear;
    logic            w_skid_valid;
    logic [XLEN-1:0] w_skid_pc;
    logic [XLEN-1:0] w_skid_instr;

    // Redirects are ignored during BOOT; an ack only counts while a request is presented.
    assign w_redirect = i_branch_taken && (r_state != FETCH_BOOT);
    assign w_ack      = i_imem_ack && (r_state == FETCH_REQ);
    assign w_target   = i_branch_target & ~XLEN'(3);
    assign w_pc_plus4 = r_pc + XLEN'(4);

    // A clean response goes straight to IF/ID unless IF/ID is occupied and stalled.
    assign w_deliver  = w_ack && !w_redirect && !r_pend_valid && (!i_stall || !r_if_valid);
    assign w_skid_pop = (r_state == FETCH_HOLD) && !w_redirect && !i_stall && w_skid_valid;

    // PC-next mux and skid control.
    always_comb begin
        w_pc_next    = r_pc;
        w_skid_load  = 1'b0;
        w_skid_clear = w_redirect;
        case (r_state)
            FETCH_REQ: begin
                if (w_redirect) begin
                    if (i_imem_ack) begin
                        w_pc_next = w_target;
                    end
                end else if (i_imem_ack) begin
                    if (r_pend_valid) begin
                        w_pc_next = r_pend_target;
                    end else begin
                        w_pc_next   = w_pc_plus4;
                        w_skid_load = i_stall && r_if_valid;
                    end
                end
            end
            FETCH_HOLD: begin
                if (w_redirect) begin
                    w_pc_next = w_target;
                end else if (!i_stall) begin
                    w_skid_clear = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Fetch FSM: state, PC, request strobe and pending-redirect bookkeeping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= FETCH_BOOT;
            r_pc          <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else begin
            r_pc <= w_pc_next;
            case (r_state)
                FETCH_BOOT: begin
                    r_state    <= FETCH_REQ;
                    r_imem_req <= 1'b1;
                end
                FETCH_REQ: begin
                    if (w_redirect && !i_imem_ack) begin
                        // Request still in flight: remember the youngest target.
                        r_pend_valid  <= 1'b1;
                        r_pend_target <= w_target;
                    end else if (i_imem_ack) begin
                        r_pend_valid <= 1'b0;
                        if (w_skid_load) begin
                            r_state    <= FETCH_HOLD;
                            r_imem_req <= 1'b0;
                        end
                    end
                end
                FETCH_HOLD: begin
                    if (w_redirect || !i_stall) begin
                        r_state    <= FETCH_REQ;
                        r_imem_req <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= FETCH_BOOT;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID register: flush beats stall, stall freezes, otherwise load or drain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_if_valid    <= 1'b0;
            r_if_pc       <= '0;
            r_if_pc_plus4 <= '0;
            r_if_instr    <= XLEN'(INSTR_NOP);
        end else if (w_redirect) begin
            r_if_valid <= 1'b0;
            r_if_instr <= XLEN'(INSTR_NOP);
        end else if (w_deliver) begin
            r_if_valid    <= 1'b1;
            r_if_pc       <= r_pc;
            r_if_pc_plus4 <= w_pc_plus4;
            r_if_instr    <= i_imem_rdata;
        end else if (w_skid_pop) begin
            r_if_valid    <= 1'b1;
            r_if_pc       <= w_skid_pc;
            r_if_pc_plus4 <= w_skid_pc + XLEN'(4);
            r_if_instr    <= w_skid_instr;
        end else if (!i_stall) begin
            r_if_valid <= 1'b0;
            r_if_instr <= XLEN'(INSTR_NOP);
        end
    end

    fetch_skid #(
        .XLEN (XLEN)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_pc    (r_pc),
        .i_instr (i_imem_rdata),
        .o_valid (w_skid_valid),
        .o_pc    (w_skid_pc),
        .o_instr (w_skid_instr)
    );

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_pc;
    assign o_if_valid    = r_if_valid;
    assign o_if_pc       = r_if_pc;
    assign o_if_pc_plus4 = r_if_pc_plus4;
    assign o_if_instr    = r_if_instr;

endmodule
